// File: rtl/trap_sequencer.sv
// Supervisor trap-entry / sret sequencer: drains older CSR writers, then walks the
// single CSR port through the sepc/scause/stval/sstatus/stvec accesses and redirects.
module trap_sequencer #(
    parameter int              XLEN          = 64,
    parameter logic [11:0]     CSR_SSTATUS   = 12'h100,
    parameter logic [11:0]     CSR_STVEC     = 12'h105,
    parameter logic [11:0]     CSR_SEPC      = 12'h141,
    parameter logic [11:0]     CSR_SCAUSE    = 12'h142,
    parameter logic [11:0]     CSR_STVAL     = 12'h143,
    parameter logic [XLEN-1:0] CAUSE_ECALL   = 8,
    parameter logic [XLEN-1:0] CAUSE_ILLEGAL = 2
) (
    input  logic            clk,
    input  logic            rstn,
    input  logic            trap_valid,
    input  logic [1:0]      trap,
    input  logic [XLEN-1:0] ex_pc,
    input  logic [31:0]     ex_inst,
    input  logic            drain_busy,
    input  logic [XLEN-1:0] csr_rdata,
    output logic [11:0]     csr_raddr,
    output logic            csr_we,
    output logic [11:0]     csr_waddr,
    output logic [XLEN-1:0] csr_wdata,
    output logic            stall,
    output logic            flush,
    output logic            redirect_valid,
    output logic [XLEN-1:0] redirect_pc,
    output logic            busy
);

    localparam logic [1:0] KIND_ECALL = 2'b01;
    localparam logic [1:0] KIND_SRET  = 2'b11;

    typedef enum logic [3:0] {
        IDLE, DRAIN, RD_STATUS, WR_EPC, WR_CAUSE, WR_TVAL,
        WR_STATUS, RD_VEC, RD_EPC, REDIR
    } state_t;

    state_t            state, state_next;
    logic [XLEN-1:0]   pc_q, sstatus_q, target_q, status_new;
    logic [31:0]       inst_q;
    logic [1:0]        kind_q;
    logic              accept;

    assign accept = (state == IDLE) && trap_valid && (trap != 2'b00);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state     <= IDLE;
            pc_q      <= '0;
            inst_q    <= '0;
            kind_q    <= '0;
            sstatus_q <= '0;
            target_q  <= '0;
        end else begin
            state <= state_next;
            if (accept) begin
                pc_q   <= ex_pc;
                inst_q <= ex_inst;
                kind_q <= trap;
            end
            if (state == RD_STATUS) sstatus_q <= csr_rdata;
            // stvec mode bits are dropped: only direct-mode vectoring is supported
            if (state == RD_VEC) target_q <= csr_rdata & ~XLEN'(3);
            if (state == RD_EPC) target_q <= csr_rdata;
        end
    end

    always_comb begin
        state_next     = state;
        csr_raddr      = '0;
        csr_we         = 1'b0;
        csr_waddr      = '0;
        csr_wdata      = '0;
        flush          = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        stall          = (state != IDLE) || accept;
        busy           = (state != IDLE);

        status_new = sstatus_q;
        if (kind_q == KIND_SRET) begin
            status_new[1] = sstatus_q[5];
            status_new[5] = 1'b1;
            status_new[8] = 1'b0;
        end else begin
            status_new[5] = sstatus_q[1];
            status_new[1] = 1'b0;
            status_new[8] = 1'b1;
        end

        case (state)
            IDLE:      if (accept) state_next = DRAIN;
            DRAIN:     if (!drain_busy) state_next = RD_STATUS;
            RD_STATUS: begin
                csr_raddr  = CSR_SSTATUS;
                state_next = (kind_q == KIND_SRET) ? WR_STATUS : WR_EPC;
            end
            WR_EPC: begin
                csr_we     = 1'b1;
                csr_waddr  = CSR_SEPC;
                csr_wdata  = pc_q;
                state_next = WR_CAUSE;
            end
            WR_CAUSE: begin
                csr_we     = 1'b1;
                csr_waddr  = CSR_SCAUSE;
                csr_wdata  = (kind_q == KIND_ECALL) ? CAUSE_ECALL : CAUSE_ILLEGAL;
                state_next = WR_TVAL;
            end
            WR_TVAL: begin
                csr_we     = 1'b1;
                csr_waddr  = CSR_STVAL;
                csr_wdata  = (kind_q == KIND_ECALL) ? '0 : {{(XLEN-32){1'b0}}, inst_q};
                state_next = WR_STATUS;
            end
            WR_STATUS: begin
                csr_we     = 1'b1;
                csr_waddr  = CSR_SSTATUS;
                csr_wdata  = status_new;
                state_next = (kind_q == KIND_SRET) ? RD_EPC : RD_VEC;
            end
            RD_VEC: begin
                csr_raddr  = CSR_STVEC;
                state_next = REDIR;
            end
            RD_EPC: begin
                csr_raddr  = CSR_SEPC;
                state_next = REDIR;
            end
            REDIR: begin
                flush          = 1'b1;
                redirect_valid = 1'b1;
                redirect_pc    = target_q;
                state_next     = IDLE;
            end
            default:   state_next = IDLE;
        endcase
    end

endmodule

// File: tb/tb_trap_sequencer.sv
// Directed self-checking bench for trap_sequencer with a small behavioural CSR file.
module tb_trap_sequencer;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        trap_valid = 1'b0;
    logic [1:0]  trap = 2'b00;
    logic [63:0] ex_pc = '0;
    logic [31:0] ex_inst = '0;
    logic        drain_busy = 1'b0;
    logic [63:0] csr_rdata;
    logic [11:0] csr_raddr, csr_waddr;
    logic        csr_we, stall, flush, redirect_valid, busy;
    logic [63:0] csr_wdata, redirect_pc;

    logic [63:0] r_sstatus = '0, r_stvec = '0, r_sepc = '0, r_scause = '0, r_stval = '0;
    logic        load_req = 1'b0;
    logic [11:0] load_addr = '0;
    logic [63:0] load_data = '0;

    int checks = 0, errors = 0;
    int zero_viol = 0, flush_total = 0;
    int redir_cycle, we_cnt, we_in_drain, flush_cnt;
    logic [63:0] redir_pc_seen;

    trap_sequencer dut (
        .clk(clk), .rstn(rstn), .trap_valid(trap_valid), .trap(trap),
        .ex_pc(ex_pc), .ex_inst(ex_inst), .drain_busy(drain_busy),
        .csr_rdata(csr_rdata), .csr_raddr(csr_raddr), .csr_we(csr_we),
        .csr_waddr(csr_waddr), .csr_wdata(csr_wdata), .stall(stall),
        .flush(flush), .redirect_valid(redirect_valid),
        .redirect_pc(redirect_pc), .busy(busy)
    );

    always #5 clk = ~clk;

    // Behavioural CSR file: combinational read, write on the rising edge
    always_comb begin
        csr_rdata = '0;
        case (csr_raddr)
            12'h100: csr_rdata = r_sstatus;
            12'h105: csr_rdata = r_stvec;
            12'h141: csr_rdata = r_sepc;
            12'h142: csr_rdata = r_scause;
            12'h143: csr_rdata = r_stval;
            default: csr_rdata = '0;
        endcase
    end

    always @(posedge clk) begin
        if (load_req || csr_we) begin
            case (load_req ? load_addr : csr_waddr)
                12'h100: r_sstatus <= load_req ? load_data : csr_wdata;
                12'h105: r_stvec   <= load_req ? load_data : csr_wdata;
                12'h141: r_sepc    <= load_req ? load_data : csr_wdata;
                12'h142: r_scause  <= load_req ? load_data : csr_wdata;
                12'h143: r_stval   <= load_req ? load_data : csr_wdata;
                default: ;
            endcase
        end
    end

    always @(negedge clk) begin
        if (!csr_we && (csr_waddr != 12'h0 || csr_wdata != 64'h0)) zero_viol <= zero_viol + 1;
        if (flush) flush_total <= flush_total + 1;
    end

    task automatic check_output(input string tag, input logic [63:0] observed,
                                input logic [63:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic write_csr(input logic [11:0] addr, input logic [63:0] data);
        load_addr = addr;
        load_data = data;
        load_req  = 1'b1;
        @(posedge clk);
        #1 load_req = 1'b0;
    endtask

    // Presents a trap in cycle 0 (called just after a rising edge) and runs until REDIR.
    // hold keeps a competing ecall on the inputs; abort_at pulls rstn low in that cycle.
    task automatic apply_stimulus(input logic [1:0] kind, input logic [63:0] pc,
                                  input logic [31:0] inst, input int nbusy,
                                  input bit hold, input int abort_at);
        redir_cycle = -1;
        redir_pc_seen = '0;
        we_cnt = 0;
        we_in_drain = 0;
        flush_cnt = 0;
        trap_valid = 1'b1;
        trap = kind;
        ex_pc = pc;
        ex_inst = inst;
        drain_busy = 1'b0;
        #1 check_output("stall_on_accept", {63'b0, stall}, 64'h1);
        for (int k = 1; k <= 40; k++) begin
            @(posedge clk);
            #1;
            trap_valid = hold;
            trap = hold ? 2'b01 : 2'b00;
            ex_pc = hold ? 64'hBAD0 : 64'h0;
            drain_busy = (k <= nbusy);
            @(negedge clk);
            if (csr_we) begin
                we_cnt++;
                if (k <= nbusy + 2) we_in_drain++;
            end
            if (flush) flush_cnt++;
            if (k == abort_at) begin
                #1 rstn = 1'b0;
                #1;
                return;
            end
            if (redirect_valid) begin
                redir_cycle = k;
                redir_pc_seen = redirect_pc;
                break;
            end
        end
        @(posedge clk);
        #1;
        trap_valid = 1'b0;
        trap = 2'b00;
        drain_busy = 1'b0;
    endtask

    task automatic check_quiet(input string tag);
        check_output({tag, "_ctrl"}, {59'b0, stall, busy, flush, redirect_valid, csr_we}, 64'h0);
        check_output({tag, "_addr"}, {40'b0, csr_raddr, csr_waddr}, 64'h0);
        check_output({tag, "_wdata"}, csr_wdata, 64'h0);
        check_output({tag, "_rpc"}, redirect_pc, 64'h0);
    endtask

    initial begin
        int flush_before;
        repeat (2) @(posedge clk);
        #1 check_quiet("reset");
        @(negedge clk) rstn = 1'b1;
        @(posedge clk);
        #1;

        // ecall with no drain
        write_csr(12'h100, 64'h2);
        write_csr(12'h105, 64'h80001001);
        write_csr(12'h143, 64'hDEAD);
        apply_stimulus(2'b01, 64'h80000010, 32'h00000073, 0, 1'b0, 0);
        check_output("ecall_cycle", 64'(redir_cycle), 64'd8);
        check_output("ecall_rpc", redir_pc_seen, 64'h80001000);
        check_output("ecall_sepc", r_sepc, 64'h80000010);
        check_output("ecall_scause", r_scause, 64'd8);
        check_output("ecall_stval", r_stval, 64'h0);
        check_output("ecall_sstatus", r_sstatus, 64'h120);
        check_output("ecall_we_cnt", 64'(we_cnt), 64'd4);
        check_output("ecall_idle_after", {62'b0, busy, flush}, 64'h0);

        // unimp: illegal-instruction cause, stval carries the encoding
        apply_stimulus(2'b10, 64'h80000020, 32'hC0001073, 0, 1'b0, 0);
        check_output("unimp_cycle", 64'(redir_cycle), 64'd8);
        check_output("unimp_scause", r_scause, 64'd2);
        check_output("unimp_stval", r_stval, 64'hC0001073);
        check_output("unimp_sepc", r_sepc, 64'h80000020);
        check_output("unimp_sstatus", r_sstatus, 64'h100);

        // sret
        write_csr(12'h141, 64'h80000014);
        write_csr(12'h100, 64'h120);
        apply_stimulus(2'b11, 64'h80000040, 32'h10200073, 0, 1'b0, 0);
        check_output("sret_cycle", 64'(redir_cycle), 64'd5);
        check_output("sret_rpc", redir_pc_seen, 64'h80000014);
        check_output("sret_sstatus", r_sstatus, 64'h22);
        check_output("sret_we_cnt", 64'(we_cnt), 64'd1);

        // ecall behind three drain cycles
        apply_stimulus(2'b01, 64'h80000030, 32'h00000073, 3, 1'b0, 0);
        check_output("drain_cycle", 64'(redir_cycle), 64'd11);
        check_output("drain_no_we", 64'(we_in_drain), 64'd0);
        check_output("drain_sepc", r_sepc, 64'h80000030);
        check_output("drain_sstatus", r_sstatus, 64'h120);

        // sret with a competing ecall held through busy and REDIR cycles
        flush_before = flush_total;
        apply_stimulus(2'b11, 64'h80000070, 32'h10200073, 0, 1'b1, 0);
        check_output("hold_cycle", 64'(redir_cycle), 64'd5);
        check_output("hold_rpc", redir_pc_seen, 64'h80000030);
        check_output("hold_idle", {63'b0, busy}, 64'h0);
        repeat (3) @(posedge clk);
        #1;
        check_output("hold_flush_pulses", 64'(flush_total - flush_before), 64'd1);
        check_output("hold_sepc", r_sepc, 64'h80000030);
        check_output("hold_sstatus", r_sstatus, 64'h22);
        check_output("hold_still_idle", {63'b0, busy}, 64'h0);

        // reset during WR_CAUSE, then a clean ecall
        write_csr(12'h142, 64'h33);
        apply_stimulus(2'b01, 64'h80000050, 32'h00000073, 0, 1'b0, 4);
        check_quiet("abort");
        check_output("abort_sepc_kept", r_sepc, 64'h80000050);
        check_output("abort_scause_untouched", r_scause, 64'h33);
        @(negedge clk) rstn = 1'b1;
        @(posedge clk);
        #1;
        apply_stimulus(2'b01, 64'h80000060, 32'h00000073, 0, 1'b0, 0);
        check_output("post_cycle", 64'(redir_cycle), 64'd8);
        check_output("post_rpc", redir_pc_seen, 64'h80001000);
        check_output("post_sepc", r_sepc, 64'h80000060);
        check_output("post_scause", r_scause, 64'd8);
        check_output("post_sstatus", r_sstatus, 64'h120);

        check_output("wport_zero_when_idle", 64'(zero_viol), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
